// File: rtl/led_blink_ctrl.sv
// Memory-mapped LED blink controller: per-channel off/on/blink/counted-burst
// modes driven from one prescaled tick and a shared half-period phase.
module led_blink_ctrl #(
    parameter int N_CH     = 16,
    parameter int DIV      = 100000,
    parameter int PERIOD_W = 16,
    parameter int BURST_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic            re,
    input  logic [2:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic [N_CH-1:0] leds
);
    localparam int                  TICK_W     = $clog2(DIV);
    localparam logic [TICK_W-1:0]   TICK_LAST  = TICK_W'(DIV - 1);
    localparam logic [PERIOD_W-1:0] PERIOD_RST = PERIOD_W'(500);
    localparam logic [BURST_W-1:0]  BURST_RST  = BURST_W'(3);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_BURST = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        REG_ENABLE = 3'd0,
        REG_MODE   = 3'd1,
        REG_PERIOD = 3'd2,
        REG_BURST  = 3'd3,
        REG_STATUS = 3'd4
    } reg_e;

    logic [N_CH-1:0]     enable_q;
    logic [2*N_CH-1:0]   mode_q;
    logic [PERIOD_W-1:0] period_q;
    logic [BURST_W-1:0]  burst_q;
    logic [N_CH-1:0]     done_q;
    logic [N_CH-1:0]     zero_pend_q;
    logic [BURST_W-1:0]  remain_q [N_CH];

    logic [TICK_W-1:0]   tick_cnt_q;
    logic [PERIOD_W-1:0] half_cnt_q;
    logic                phase_q;

    logic wr_enable, wr_mode, wr_period, wr_burst, wr_status;
    logic tick, half_done, phase_fall;
    logic [PERIOD_W-1:0] half_last;

    logic [N_CH-1:0] load, dec, set_v, clr_v, done_d, leds_d;
    logic [31:0]     rd_mux;

    assign wr_enable = we && (addr == REG_ENABLE);
    assign wr_mode   = we && (addr == REG_MODE);
    assign wr_period = we && (addr == REG_PERIOD);
    assign wr_burst  = we && (addr == REG_BURST);
    assign wr_status = we && (addr == REG_STATUS);

    // A programmed half-period of 0 behaves like 1.
    assign half_last  = (period_q == '0) ? '0 : period_q - 1'b1;
    assign tick       = (tick_cnt_q == TICK_LAST);
    assign half_done  = tick && (half_cnt_q == half_last);
    assign phase_fall = half_done && phase_q && !wr_period;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_q <= '0;
            half_cnt_q <= '0;
            phase_q    <= 1'b0;
        end else if (wr_period) begin
            tick_cnt_q <= '0;
            half_cnt_q <= '0;
            phase_q    <= 1'b0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            if (half_done) begin
                half_cnt_q <= '0;
                phase_q    <= ~phase_q;
            end else if (tick) begin
                half_cnt_q <= half_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_q <= '0;
            mode_q   <= '0;
            period_q <= PERIOD_RST;
            burst_q  <= BURST_RST;
        end else begin
            if (wr_enable) enable_q <= wdata[N_CH-1:0];
            if (wr_mode)   mode_q   <= wdata[2*N_CH-1:0];
            if (wr_period) period_q <= wdata[PERIOD_W-1:0];
            if (wr_burst)  burst_q  <= wdata[BURST_W-1:0];
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        load   = '0;
        dec    = '0;
        set_v  = '0;
        clr_v  = '0;
        done_d = '0;
        leds_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            load[i]  = wr_mode && (mode_e'(wdata[2*i +: 2]) == MODE_BURST);
            dec[i]   = phase_fall && enable_q[i] && !load[i]
                       && (mode_e'(mode_q[2*i +: 2]) == MODE_BURST)
                       && (remain_q[i] != '0);
            // Hardware completion beats a same-cycle W1C; a reload beats both.
            set_v[i] = ((dec[i] && (remain_q[i] == BURST_W'(1))) || zero_pend_q[i]) && !load[i];
            clr_v[i] = (wr_status && wdata[i]) || load[i];
            done_d[i] = set_v[i] || (done_q[i] && !clr_v[i]);
            if (enable_q[i]) begin
                case (mode_e'(mode_q[2*i +: 2]))
                    MODE_OFF:   leds_d[i] = 1'b0;
                    MODE_ON:    leds_d[i] = 1'b1;
                    MODE_BLINK: leds_d[i] = phase_q;
                    MODE_BURST: leds_d[i] = phase_q && (remain_q[i] != '0);
                    default:    leds_d[i] = 1'b0;
                endcase
            end
        end
    end

    // NOTE: remain is a handful of per-channel counters, so it is reset like plain flops rather than treated as RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) remain_q[i] <= '0;
            done_q      <= '0;
            zero_pend_q <= '0;
            leds        <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (load[i])     remain_q[i] <= burst_q;
                else if (dec[i]) remain_q[i] <= remain_q[i] - 1'b1;
            end
            done_q      <= done_d;
            zero_pend_q <= load & {N_CH{burst_q == '0}};
            leds        <= leds_d;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            REG_ENABLE: rd_mux[N_CH-1:0]     = enable_q;
            REG_MODE:   rd_mux[2*N_CH-1:0]   = mode_q;
            REG_PERIOD: rd_mux[PERIOD_W-1:0] = period_q;
            REG_BURST:  rd_mux[BURST_W-1:0]  = burst_q;
            REG_STATUS: rd_mux[N_CH-1:0]     = done_q;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  rdata <= '0;
        else if (re) rdata <= rd_mux;
    end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Self-checking bench for led_blink_ctrl: directed scenarios plus random bus
// traffic, compared every cycle against a time-based behavioural model.
module tb_led_blink_ctrl;
    localparam int N = 4;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          we, re;
    logic [2:0]    addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [N-1:0]  leds;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    led_blink_ctrl #(.N_CH(N), .DIV(D), .PERIOD_W(16), .BURST_W(8)) dut (
        .clk(clk), .reset(reset), .we(we), .re(re), .addr(addr),
        .wdata(wdata), .rdata(rdata), .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase is derived from the number of clocks since the last
    // PERIOD write or reset; bursts count falling phase edges.
    longint       m_n;
    logic [N-1:0] m_en;
    logic [2*N-1:0] m_mode;
    int unsigned  m_period, m_burst;
    int           m_remain [N];
    logic [N-1:0] m_done, m_zpend, m_leds;
    logic [31:0]  m_rdata;

    function automatic bit phase_at(longint cyc, int unsigned p);
        longint pe = (p == 0) ? 64'd1 : longint'(p);
        return bit'(((cyc / D) / pe) % 2);
    endfunction

    task automatic model_reset();
        m_n = 0; m_en = '0; m_mode = '0; m_period = 500; m_burst = 3;
        for (int i = 0; i < N; i++) m_remain[i] = 0;
        m_done = '0; m_zpend = '0; m_leds = '0; m_rdata = '0;
    endtask

    task automatic model_step();
        bit ph, fall, wr_p, ld, dc, st, cl;
        logic [N-1:0] out, nzp;
        wr_p = we && addr == 3'd2;
        ph   = phase_at(m_n, m_period);
        fall = ph && !phase_at(m_n + 1, m_period) && !wr_p;
        out  = '0;
        nzp  = '0;
        for (int i = 0; i < N; i++) begin
            if (m_en[i]) begin
                case (m_mode[2*i +: 2])
                    2'b01: out[i] = 1'b1;
                    2'b10: out[i] = ph;
                    2'b11: out[i] = ph && (m_remain[i] != 0);
                    default: out[i] = 1'b0;
                endcase
            end
        end
        if (re) begin
            m_rdata = '0;
            case (addr)
                3'd0: m_rdata[N-1:0]   = m_en;
                3'd1: m_rdata[2*N-1:0] = m_mode;
                3'd2: m_rdata = m_period;
                3'd3: m_rdata = m_burst;
                3'd4: m_rdata[N-1:0]   = m_done;
                default: m_rdata = '0;
            endcase
        end
        for (int i = 0; i < N; i++) begin
            ld = we && addr == 3'd1 && wdata[2*i +: 2] == 2'b11;
            dc = fall && m_en[i] && m_mode[2*i +: 2] == 2'b11 && m_remain[i] != 0 && !ld;
            st = ((dc && m_remain[i] == 1) || m_zpend[i]) && !ld;
            cl = (we && addr == 3'd4 && wdata[i]) || ld;
            m_done[i] = st || (m_done[i] && !cl);
            nzp[i] = ld && (m_burst == 0);
            if (ld) m_remain[i] = int'(m_burst);
            else if (dc) m_remain[i] = m_remain[i] - 1;
        end
        m_zpend = nzp;
        if (we) begin
            case (addr)
                3'd0: m_en = wdata[N-1:0];
                3'd1: m_mode = wdata[2*N-1:0];
                3'd2: m_period = wdata[15:0];
                3'd3: m_burst = wdata[7:0];
                default: ;
            endcase
        end
        m_n = wr_p ? 0 : m_n + 1;
        m_leds = out;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("leds_vs_model", leds, m_leds);
            check("rdata_vs_model", rdata, m_rdata);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        re = 1'b1; addr = a;
        @(posedge clk); #1;
        re = 1'b0;
        d = rdata;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int rise_at, highs, pulses, late_hi;
        logic l24, l25, prev;
        logic [31:0] exp_rst [5];
        exp_rst[0] = 0; exp_rst[1] = 0; exp_rst[2] = 500; exp_rst[3] = 3; exp_rst[4] = 0;

        // Reset with random bus activity
        reset = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
        @(posedge clk); #1;
        cmp_en = 1'b1;
        repeat (6) begin
            we = 1'($urandom); re = 1'($urandom);
            addr = 3'($urandom); wdata = $urandom;
            @(posedge clk); #1;
        end
        we = 1'b0; re = 1'b0;
        check("reset_leds", leds, 0);
        reset = 1'b1;
        for (int a = 0; a < 5; a++) begin
            rd(3'(a), v);
            check($sformatf("reset_reg%0d", a), v, exp_rst[a]);
        end

        // Steady + blink
        wr(3'd0, 32'h3);
        wr(3'd1, 32'h9);
        wr(3'd2, 32'd3);
        rise_at = 0; l24 = 1'b0; l25 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (leds[1] && rise_at == 0) rise_at = k;
            if (k == 24) l24 = leds[1];
            if (k == 25) l25 = leds[1];
        end
        check("blink_first_rise", rise_at, 13);
        check("blink_high_before_fall", l24, 1);
        check("blink_fall", l25, 0);
        check("steady_on", leds[0], 1);

        // Counted burst on ch2
        wr(3'd2, 32'd2);
        wr(3'd3, 32'd3);
        wr(3'd0, 32'h7);
        wr(3'd1, 32'h39);
        highs = 0; pulses = 0; prev = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (leds[2]) begin
                highs++;
                if (!prev) pulses++;
            end
            prev = leds[2];
        end
        check("burst_pulses", pulses, 3);
        check("burst_high_cycles", highs, 24);
        rd(3'd4, v);
        check("burst_done", v[2], 1);
        check("burst_idle_low", leds[2], 0);
        wr(3'd4, 32'h4);
        rd(3'd4, v);
        check("burst_done_w1c", v[2], 0);

        // BURST=0 load, with W1C colliding with the completion set
        wr(3'd3, 32'd0);
        wr(3'd1, 32'h39);
        wr(3'd4, 32'h4);
        rd(3'd4, v);
        check("zero_burst_set_wins", v[2], 1);
        highs = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (leds[2]) highs++;
        end
        check("zero_burst_no_pulse", highs, 0);

        // Reload mid-burst, freeze while disabled, resume
        wr(3'd3, 32'd3);
        wr(3'd1, 32'h39);
        rd(3'd4, v);
        check("reload_clears_done", v[2], 0);
        idle(10);
        wr(3'd0, 32'h3);
        highs = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (leds[2]) highs++;
        end
        check("disabled_low", highs, 0);
        rd(3'd4, v);
        check("disabled_frozen", v[2], 0);
        wr(3'd0, 32'h7);
        idle(100);
        rd(3'd4, v);
        check("resume_completes", v[2], 1);

        // PERIOD write coincident with the terminal tick
        wr(3'd2, 32'd1);
        idle(3);
        wr(3'd2, 32'd1);
        late_hi = 0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k <= 4 && leds[1]) late_hi++;
            if (k == 5) check("period_collision_rise", leds[1], 1);
        end
        check("period_collision_quiet", late_hi, 0);

        // Asynchronous reset between clock edges
        #2 reset = 1'b0;
        #1 check("async_reset_leds", leds, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        rd(3'd2, v);
        check("async_reset_period", v, 500);

        // Random traffic
        for (int op = 0; op < 600; op++) begin
            case ($urandom_range(0, 9))
                0, 1: wr(3'd0, $urandom);
                2, 3: wr(3'd1, $urandom);
                4:    wr(3'd2, $urandom_range(0, 3));
                5:    wr(3'd3, $urandom_range(0, 3));
                6:    wr(3'd4, $urandom);
                7:    wr(3'($urandom_range(5, 7)), $urandom);
                8:    rd(3'($urandom_range(0, 7)), v);
                default: idle($urandom_range(1, 12));
            endcase
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
